// File: rtl/riscv_pkg.sv
// Shared register-file types and widths for the integer pipeline.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode/regfile/write-back/execute signal bundle around the operand-fetch stage.
interface operand_fetch_if;
  import riscv_pkg::*;

  logic      issue_valid;
  logic      issue_ready;
  reg_addr_t issue_rs1;
  reg_addr_t issue_rs2;
  reg_addr_t issue_rd;
  logic      issue_rd_wen;
  reg_addr_t addr_a;
  reg_addr_t addr_b;
  word_t     data_a;
  word_t     data_b;
  logic      reg_write;
  reg_addr_t addr_write;
  word_t     data_write;
  logic      op_valid;
  logic      op_ready;
  word_t     op_a;
  word_t     op_b;
  reg_addr_t op_rd;
  logic      op_rd_wen;

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_wen,
    input  data_a, data_b, reg_write, addr_write, data_write, op_ready,
    output issue_ready, addr_a, addr_b, op_valid, op_a, op_b, op_rd, op_rd_wen
  );

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_wen,
    output data_a, data_b, reg_write, addr_write, data_write, op_ready,
    input  issue_ready, addr_a, addr_b, op_valid, op_a, op_b, op_rd, op_rd_wen
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write bit per architectural register; x0 never pending.
// Same-cycle set and clear of one index leaves the bit set.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_idx,
  input  logic      clr_en,
  input  reg_addr_t clr_idx,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  output logic      rs1_pend,
  output logic      rs2_pend,
  output logic      rd_pend,
  output logic      rs1_clr,
  output logic      rs2_clr,
  output logic      rd_clr
);
  logic [NUM_REGS-1:0] pend, pend_nxt;

  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign rs1_pend = pend[rs1];
  assign rs2_pend = pend[rs2];
  assign rd_pend  = pend[rd];
  assign rs1_clr  = clr_en && (clr_idx == rs1) && (rs1 != '0);
  assign rs2_clr  = clr_en && (clr_idx == rs2) && (rs2 != '0);
  assign rd_clr   = clr_en && (clr_idx == rd)  && (rd  != '0);
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: scoreboarded register read with registered output to execute.
// Define OPFETCH_BYPASS_EN for same-cycle write-back bypass of source operands.
module operand_fetch
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  operand_fetch_if.slave  bus
);
  localparam int NSRC = 2;

  logic [NSRC-1:0][REG_AW-1:0] src;
  logic [NSRC-1:0][XLEN-1:0]   rf_d;
  logic [NSRC-1:0][XLEN-1:0]   opnd;
  logic [NSRC-1:0]             src_pend, src_clr, src_hz;
  logic                        rd_pend, rd_clr, hazard, accept;

  assign src       = {bus.issue_rs2, bus.issue_rs1};
  assign rf_d      = {bus.data_b, bus.data_a};
  assign bus.addr_a = bus.issue_rs1;
  assign bus.addr_b = bus.issue_rs2;

  reg_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (accept && bus.issue_rd_wen),
    .set_idx  (bus.issue_rd),
    .clr_en   (bus.reg_write),
    .clr_idx  (bus.addr_write),
    .rs1      (bus.issue_rs1),
    .rs2      (bus.issue_rs2),
    .rd       (bus.issue_rd),
    .rs1_pend (src_pend[0]),
    .rs2_pend (src_pend[1]),
    .rd_pend  (rd_pend),
    .rs1_clr  (src_clr[0]),
    .rs2_clr  (src_clr[1]),
    .rd_clr   (rd_clr)
  );

  for (genvar s = 0; s < NSRC; s++) begin : g_src
`ifdef OPFETCH_BYPASS_EN
    assign src_hz[s] = src_pend[s] && !src_clr[s];
    assign opnd[s]   = (src[s] == '0) ? '0 :
                       (bus.reg_write && bus.addr_write == src[s]) ? bus.data_write : rf_d[s];
`else
    // Without bypass the clearing cycle still stalls so the next read sees the written file.
    assign src_hz[s] = src_pend[s];
    assign opnd[s]   = (src[s] == '0) ? '0 : rf_d[s];
`endif
  end

`ifndef OPFETCH_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{src_clr, bus.data_write};
`endif

  // An in-flight write to rd retiring this cycle no longer blocks a new writer.
  assign hazard = (|src_hz) || (rd_pend && !rd_clr);
  assign bus.issue_ready = reset && !hazard && (!bus.op_valid || bus.op_ready);
  assign accept = bus.issue_valid && bus.issue_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.op_valid  <= 1'b0;
      bus.op_a      <= '0;
      bus.op_b      <= '0;
      bus.op_rd     <= '0;
      bus.op_rd_wen <= 1'b0;
    end else if (accept) begin
      bus.op_valid  <= 1'b1;
      bus.op_a      <= opnd[0];
      bus.op_b      <= opnd[1];
      bus.op_rd     <= bus.issue_rd;
      bus.op_rd_wen <= bus.issue_rd_wen;
    end else if (bus.op_ready) begin
      bus.op_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  word_t rf [NUM_REGS];

  operand_fetch_if bus ();

  operand_fetch dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.reg_write && bus.addr_write != '0) rf[bus.addr_write] <= bus.data_write;

  assign bus.data_a = (bus.addr_a == '0) ? '0 : rf[bus.addr_a];
  assign bus.data_b = (bus.addr_b == '0) ? '0 : rf[bus.addr_b];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input reg_addr_t a, input word_t d);
    bus.reg_write  = 1'b1;
    bus.addr_write = a;
    bus.data_write = d;
  endtask

  task automatic iss(input reg_addr_t r1, input reg_addr_t r2, input reg_addr_t rd, input logic wen);
    bus.issue_valid  = 1'b1;
    bus.issue_rs1    = r1;
    bus.issue_rs2    = r2;
    bus.issue_rd     = rd;
    bus.issue_rd_wen = wen;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.reg_write   = 1'b0;
  endtask

  initial begin
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0;
    bus.issue_rd_wen = 0; bus.reg_write = 0; bus.addr_write = 0; bus.data_write = 0;
    bus.op_ready = 1;
    tick(); tick();
    chk("rst_op_valid", 32'(bus.op_valid), 0);
    chk("rst_ready", 32'(bus.issue_ready), 0);
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_rd", 32'(bus.op_rd), 0);
    reset = 1'b1;
    #1 chk("rel_ready", 32'(bus.issue_ready), 1);

    // basic read
    tick(); wr(4, 45);
    tick(); wr(5, 64);
    tick(); idle(); iss(5, 4, 0, 0);
    #1 chk("addr_a", 32'(bus.addr_a), 5);
    chk("addr_b", 32'(bus.addr_b), 4);
    tick(); idle();
    chk("rd_valid", 32'(bus.op_valid), 1);
    chk("rd_op_a", bus.op_a, 64);
    chk("rd_op_b", bus.op_b, 45);
    tick();
    chk("drain_valid", 32'(bus.op_valid), 0);

    // x0 reads zero, write to x0 never bypassed, rd=0 wen passes through
    wr(0, 256);
    tick(); idle(); iss(0, 4, 0, 1);
    tick(); idle();
    chk("x0_op_a", bus.op_a, 0);
    chk("x0_op_b", bus.op_b, 45);
    chk("x0_rd_wen", 32'(bus.op_rd_wen), 1);
    iss(0, 0, 3, 0); wr(0, 256);
    tick(); idle();
    chk("x0_byp_a", bus.op_a, 0);
    chk("x0_byp_b", bus.op_b, 0);
    chk("rd_wen_0", 32'(bus.op_rd_wen), 0);

    // RAW on x7
    iss(1, 2, 7, 1);
    tick(); idle(); iss(7, 5, 0, 0);
    #1 chk("raw_stall0", 32'(bus.issue_ready), 0);
    tick();
    chk("raw_stall1", 32'(bus.issue_ready), 0);
    wr(7, 99);
`ifdef OPFETCH_BYPASS_EN
    #1 chk("raw_wb_ready", 32'(bus.issue_ready), 1);
    tick(); idle();
`else
    #1 chk("raw_wb_ready", 32'(bus.issue_ready), 0);
    tick(); bus.reg_write = 0;
    #1 chk("raw_post_ready", 32'(bus.issue_ready), 1);
    tick(); idle();
`endif
    chk("raw_valid", 32'(bus.op_valid), 1);
    chk("raw_op_a", bus.op_a, 99);
    chk("raw_op_b", bus.op_b, 64);

    // backpressure
    iss(4, 5, 10, 0);
    tick(); idle(); bus.op_ready = 0; iss(5, 4, 11, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(bus.issue_ready), 0);
      tick();
      chk("bp_valid", 32'(bus.op_valid), 1);
      chk("bp_op_a", bus.op_a, 45);
      chk("bp_op_b", bus.op_b, 64);
      chk("bp_op_rd", 32'(bus.op_rd), 10);
    end
    bus.op_ready = 1;
    #1 chk("bp_release", 32'(bus.issue_ready), 1);
    tick(); idle();
    chk("bp_next_a", bus.op_a, 64);
    chk("bp_next_rd", 32'(bus.op_rd), 11);

    // WAW with simultaneous set/clear on x9
    iss(0, 0, 9, 1);
    tick(); idle(); iss(0, 0, 9, 1);
    #1 chk("waw_stall", 32'(bus.issue_ready), 0);
    tick();
    wr(9, 5);
    #1 chk("waw_clr_ready", 32'(bus.issue_ready), 1);
    tick(); idle();
    chk("waw_op_rd", 32'(bus.op_rd), 9);
    chk("waw_rd_wen", 32'(bus.op_rd_wen), 1);
    iss(9, 0, 0, 0);
    #1 chk("waw_still_pend", 32'(bus.issue_ready), 0);

    // reset mid-stream: held operand and pending x9 discarded
    idle(); iss(4, 0, 12, 0);
    tick(); idle(); bus.op_ready = 0;
    chk("mid_valid", 32'(bus.issue_ready | 32'(bus.op_valid)), 1);
    tick();
    reset = 1'b0;
    #1 chk("async_valid", 32'(bus.op_valid), 0);
    chk("async_ready", 32'(bus.issue_ready), 0);
    chk("async_op_a", bus.op_a, 0);
    tick();
    reset = 1'b1; bus.op_ready = 1; iss(9, 0, 0, 0);
    #1 chk("post_rst_ready", 32'(bus.issue_ready), 1);
    tick(); idle();
    chk("post_rst_op_a", bus.op_a, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that drives the read side of the 32x32 register file. It accepts decoded instructions over a valid/ready handshake and presents `addr_a`/`addr_b` to the register file. It returns registered operands to the execute stage, tracking in-flight destination registers in a scoreboard so no stale operand is ever issued. It sits between decode and execute and snoops the register-file write port (`reg_write`/`addr_write`/`data_write`) to clear pending writes and bypass write-back data.

## Interface
- `XLEN`, 32, operand width
- `REG_AW`, 5, register address width (32 registers, x0 hardwired zero)
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low
- `issue_valid` in 1 — decode presents an instruction
- `issue_ready` out 1 — stage accepts this cycle
- `issue_rs1`, `issue_rs2` in REG_AW — source registers
- `issue_rd` in REG_AW — destination register
- `issue_rd_wen` in 1 — instruction will write `issue_rd`
- `addr_a`, `addr_b` out REG_AW — register-file read addresses (combinational = `issue_rs1`/`issue_rs2`)
- `data_a`, `data_b` in XLEN — register-file combinational read data
- `reg_write` in 1 — write-back strobe (same signal driving the register file)
- `addr_write` in REG_AW — write-back address
- `data_write` in XLEN — write-back data
- `op_valid` out 1 — operands valid to execute
- `op_ready` in 1 — execute accepts
- `op_a`, `op_b` out XLEN — operands
- `op_rd` out REG_AW, `op_rd_wen` out 1 — forwarded destination info

## Operation
- Scoreboard: 32 pending bits; bit 0 permanently 0.
- Clear: `reg_write` clears `pending[addr_write]` at the edge.
- Set: accept with `issue_rd_wen && issue_rd != 0` sets `pending[issue_rd]` at the edge. Simultaneous set and clear of the same index: set wins.
- Hazard: `rs1`/`rs2` pending and not cleared this cycle (bypass build), or rd pending (WAW). Source index 0 is never a hazard.
- `issue_ready = reset_n && !hazard && (!op_valid || op_ready)`. Accept = `issue_valid && issue_ready`.
- Operand select per source: rs == 0 gives 0. `reg_write && addr_write == rs` gives `data_write` (bypass). Otherwise `data_a`/`data_b`. A write to x0 is never bypassed.
- Output register loads on accept. `op_valid` clears on `op_ready` without accept. Outputs are held stable while `op_valid && !op_ready`.
- `issue_rd_wen` with `issue_rd == 0`: passes through to `op_rd_wen`; no scoreboard effect.

## Timing
- Latency: accept at edge N gives `op_valid` high after edge N. Throughput is one per cycle when there are no hazards and `op_ready` is high.
- A source made pending by instruction at edge N stalls issue until the cycle its write-back `reg_write` is observed. With bypass, issue resumes in that same cycle.
- Reset values: `op_valid` 0, `op_a`/`op_b` 0, `op_rd` 0, `op_rd_wen` 0, all pending bits 0.
- While `reset` is low, `issue_ready` is 0.
- Reset mid-operation discards the held operand and all pending state immediately. Write-backs arriving after reset release clear already-clear bits harmlessly.

## Configuration
- `OPFETCH_BYPASS_EN` defined: same-cycle write-back bypass as above. A pending source being cleared this cycle is not a hazard.
- Undefined: no bypass mux. A source is a hazard whenever its pending bit is set, including the clearing cycle, so issue resumes one cycle after write-back and reads the updated register file. Operand select reduces to x0-zero or register-file data.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `REG_AW`, `NUM_REGS` = 32, `reg_addr_t`, `word_t`.
- Sub-module `reg_scoreboard`:
  - inputs: set and clear ports
  - outputs: pending-vector lookups for rs1/rs2/rd and same-cycle-clear indication
  - x0 forced clear

## Test plan
- After reset: hold `reset` low mid-stream with `op_valid` = 1 → `op_valid` 0 and `issue_ready` 0 asynchronously. After release with the scoreboard empty, `issue_ready` returns to 1.
- Write 45 to x4 and 64 to x5 via `reg_write`, then issue rs1 = 5, rs2 = 4 → next cycle `op_a` = 64, `op_b` = 45, `op_valid` = 1.
- Write 256 to x0, then issue rs1 = 0 → `op_a` = 0. Also issue rs1 = 0 with `reg_write` to x0 in the same cycle → no bypass, `op_a` = 0.
- RAW hazard: issue rd = 7 (wen), then rs1 = 7 → `issue_ready` 0 until `reg_write` addr 7 data 99 arrives.
  - Bypass build: accepted that cycle, `op_a` = 99.
  - Without `OPFETCH_BYPASS_EN`: accepted one cycle later, `op_a` = 99 from the register file.
- Backpressure: `op_ready` 0 for 3 cycles with a second instruction waiting → `op_a`/`op_b`/`op_rd` stable and `issue_ready` 0. On `op_ready` = 1, the second instruction is accepted in the same cycle.
- WAW plus simultaneous set/clear: with x9 pending, issue rd = 9 → stalled. In the cycle `reg_write` to x9 fires, issue is accepted and `pending[9]` remains 1 afterward.
